// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bundle between the MEM stage and dmem_lsu
//   req_valid/req_ready : request handshake
//   req_we, req_addr, req_size, req_signed, req_wdata : access description
//   resp_valid, resp_data, resp_err : one-cycle response
interface dmem_lsu_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   localparam int OFS = $clog2(DATA_WIDTH / 8);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [ADDR_WIDTH+OFS-1:0] req_addr;
   logic [1:0]                req_size;
   logic                      req_signed;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic                      resp_valid;
   logic [DATA_WIDTH-1:0]     resp_data;
   logic                      resp_err;
   modport master (
      output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
      input  req_ready, resp_valid, resp_data, resp_err
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: word RAM behind a byte-addressed load/store front end with post-reset clear sweep
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_lsu_if.slave (request handshake in, one-cycle-latency response out)
module dmem_lsu #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter bit CLEAR_ON_RESET = 1
) (
   input  logic      clk,
   input  logic      rst,
   dmem_lsu_if.slave bus
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(LANES);
   typedef enum logic {CLEAR, RUN} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q, wdata_sh, shifted, keep, ext;
   logic [ADDR_WIDTH-1:0] idx;
   logic [OFS-1:0]        ofs, ofs_q;
   logic [1:0]            size_q;
   logic [LANES-1:0]      be;
   logic                  sgn_q, valid_q, err_q, load_q, acc, err, clr_we, sign;
   int                    nb, nbq;
   assign idx            = bus.req_addr[ADDR_WIDTH+OFS-1:OFS];
   assign ofs            = bus.req_addr[OFS-1:0];
   assign bus.req_ready  = state_q == RUN && !rst;
   assign acc            = bus.req_valid && bus.req_ready;
   assign clr_we         = state_q == CLEAR && !rst && CLEAR_ON_RESET;
   assign wdata_sh       = bus.req_wdata << {ofs, 3'b000};
   assign bus.resp_valid = valid_q;
   assign bus.resp_err   = err_q;
   assign bus.resp_data  = load_q ? ext : '0;
   // The sweep ends on the last index itself, never on counter overflow.
   always_comb begin
      state_d = (state_q == CLEAR && (!CLEAR_ON_RESET || &cnt_q)) ? RUN : state_q;
      cnt_d   = state_q == CLEAR ? cnt_q + 1'b1 : cnt_q;
   end
   always_comb begin
      nb  = 1 << bus.req_size;
      err = nb > LANES || (int'(ofs) & (nb - 1)) != 0;
      for (int b = 0; b < LANES; b++)
         be[b] = acc && bus.req_we && !err && b >= int'(ofs) && b < int'(ofs) + nb;
   end
   // Load result is formed after the registered read so the RAM stays synchronous.
   always_comb begin
      nbq     = 1 << size_q;
      shifted = rdata_q >> {ofs_q, 3'b000};
      keep    = '0;
      sign    = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         keep[i] = i < 8 * nbq;
         if (i == 8 * nbq - 1) sign = shifted[i];
      end
      ext = (shifted & keep) | ({DATA_WIDTH{sign & sgn_q}} & ~keep);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= acc;
         err_q   <= acc && err;
         load_q  <= acc && !bus.req_we && !err;
      end
   end
   always_ff @(posedge clk) begin
      if (acc) begin
         size_q <= bus.req_size;
         ofs_q  <= ofs;
         sgn_q  <= bus.req_signed;
      end
   end
   always_ff @(posedge clk) begin
      if (clr_we) ram[cnt_q] <= '0;
      for (int b = 0; b < LANES; b++)
         if (be[b]) ram[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      rdata_q <= ram[idx];
   end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: byte-array reference model plus directed vectors for dmem_lsu
module tb_dmem_lsu;
   logic clk = 0;
   logic rst = 1;
   bit   armed = 0;
   int   checks = 0;
   int   errors = 0;
   dmem_lsu_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
   dmem_lsu #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   logic [7:0]  mb [64];
   bit          m_run = 0;
   int          m_cnt = 0;
   logic        exp_valid = 0, exp_err = 0;
   logic [31:0] exp_data = 0;
   always @(posedge clk) begin
      int nb;
      logic [31:0] v;
      exp_valid = 0;
      exp_err   = 0;
      exp_data  = 0;
      if (rst) begin
         m_run = 0;
         m_cnt = 0;
      end else if (!m_run) begin
         for (int k = 0; k < 4; k++) mb[4*m_cnt+k] = 8'h00;
         m_cnt++;
         if (m_cnt == 16) m_run = 1;
      end else if (bus.req_valid) begin
         nb        = 1 << bus.req_size;
         exp_valid = 1;
         exp_err   = nb > 4 || (int'(bus.req_addr) % nb) != 0;
         if (!exp_err) begin
            if (bus.req_we) begin
               for (int k = 0; k < nb; k++) mb[int'(bus.req_addr)+k] = bus.req_wdata[8*k +: 8];
            end else begin
               v = 0;
               for (int k = 0; k < nb; k++) v[8*k +: 8] = mb[int'(bus.req_addr)+k];
               if (bus.req_signed && nb < 4 && v[8*nb-1])
                  for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
               exp_data = v;
            end
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      #1;
      if (armed) begin
         chk("model.ready", 32'(bus.req_ready), 32'(m_run && !rst));
         chk("model.valid", 32'(bus.resp_valid), 32'(exp_valid));
         chk("model.err", 32'(bus.resp_err), 32'(exp_err));
         chk("model.data", bus.resp_data, exp_data);
      end
   end
   task automatic op(input logic we, input logic [5:0] a, input logic [1:0] sz, input logic sg,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee, input string nm);
      bus.req_valid  = 1;
      bus.req_we     = we;
      bus.req_addr   = a;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_wdata  = wd;
      @(posedge clk);
      @(negedge clk);
      chk({nm, ".valid"}, 32'(bus.resp_valid), 32'd1);
      chk({nm, ".data"}, bus.resp_data, ed);
      chk({nm, ".err"}, 32'(bus.resp_err), 32'(ee));
   endtask
   initial begin
      int n;
      bus.req_valid  = 0;
      bus.req_we     = 0;
      bus.req_addr   = 0;
      bus.req_size   = 0;
      bus.req_signed = 0;
      bus.req_wdata  = 0;
      repeat (3) @(posedge clk);
      armed = 1;
      @(negedge clk);
      chk("rst.ready", 32'(bus.req_ready), 32'd0);
      chk("rst.valid", 32'(bus.resp_valid), 32'd0);
      rst = 0;
      #1 chk("sweep.ready0", 32'(bus.req_ready), 32'd0);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         chk("sweep.ready", 32'(bus.req_ready), 32'd0);
      end
      @(negedge clk);
      chk("sweep.done", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < 16; i++) op(0, 6'(4*i), 2, 0, 0, 32'h0, 0, "clr.ld");
      op(1, 6'h08, 2, 0, 32'h11223344, 32'h0, 0, "st.w08");
      op(1, 6'h09, 0, 0, 32'h000000AB, 32'h0, 0, "st.b09");
      op(0, 6'h08, 2, 0, 0, 32'h1122AB44, 0, "ld.w08");
      op(0, 6'h09, 0, 0, 0, 32'h000000AB, 0, "ld.ub09");
      op(0, 6'h09, 0, 1, 0, 32'hFFFFFFAB, 0, "ld.sb09");
      op(1, 6'h0A, 1, 0, 32'h00008001, 32'h0, 0, "st.h0A");
      op(0, 6'h0A, 1, 1, 0, 32'hFFFF8001, 0, "ld.sh0A");
      op(0, 6'h0A, 1, 0, 0, 32'h00008001, 0, "ld.uh0A");
      op(1, 6'h03, 1, 0, 32'h0000FFFF, 32'h0, 1, "err.sth03");
      op(0, 6'h06, 2, 0, 0, 32'h0, 1, "err.ldw06");
      op(1, 6'h08, 3, 0, 32'hDEADBEEF, 32'h0, 1, "err.sz3");
      op(0, 6'h08, 2, 0, 0, 32'h8001AB44, 0, "err.reread08");
      op(0, 6'h00, 2, 0, 0, 32'h0, 0, "err.reread00");
      op(1, 6'h10, 2, 0, 32'hCAFEBABE, 32'h0, 0, "b2b.st");
      op(0, 6'h10, 2, 0, 0, 32'hCAFEBABE, 0, "b2b.ld1");
      op(1, 6'h13, 0, 0, 32'h00000000, 32'h0, 0, "b2b.stb");
      op(0, 6'h10, 2, 0, 0, 32'h00FEBABE, 0, "b2b.ld2");
      op(1, 6'h3F, 0, 0, 32'h0000005A, 32'h0, 0, "top.stb");
      op(0, 6'h3C, 2, 0, 0, 32'h5A000000, 0, "top.ldw");
      op(0, 6'h3F, 0, 1, 0, 32'h0000005A, 0, "top.ldsb");
      bus.req_addr = 6'h3C;
      bus.req_we   = 0;
      bus.req_size = 2;
      rst = 1;
      @(negedge clk);
      chk("rstrun.valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      rst = 0;
      repeat (7) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      n = 0;
      #1;
      while (bus.req_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("resweep.cycles", 32'(n), 32'd16);
      @(negedge clk);
      chk("resweep.valid", 32'(bus.resp_valid), 32'd1);
      chk("resweep.data", bus.resp_data, 32'h0);
      bus.req_valid = 0;
      @(negedge clk);
      chk("resweep.once", 32'(bus.resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data-memory block for the pipeline's MEM stage: a word-organised RAM behind a load/store front end. It takes byte addresses and access sizes, steers store data onto the correct byte lanes, and sign- or zero-extends loads. It flags misaligned or oversize accesses instead of performing them, and clears its entire array with a hardware sweep after reset. Requests use a valid/ready handshake, and every accepted request returns exactly one response one cycle later.

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; multiple of 8, power of two, ≥ 16
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the sweep
- Derived: LANES = DATA_WIDTH/8, OFS = log2(LANES)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH+OFS  byte address; upper ADDR_WIDTH bits = word index, low OFS bits = byte offset
- req_size  in  2  access size is 2**req_size bytes (0 = byte, 1 = half, 2 = 32-bit word, 3 = 64-bit)
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_wdata  in  DATA_WIDTH  store data, right-aligned (the low 2**req_size bytes are used)
- resp_valid  out  1  response valid, for exactly one cycle
- resp_data  out  DATA_WIDTH  load result, extended; 0 for stores and errors
- resp_err  out  1  access was misaligned or oversize, and was not performed

## Operation
- The FSM has two states, CLEAR and RUN.
- While rst = 1: state = CLEAR, clear counter = 0, all outputs are 0. If CLEAR_ON_RESET = 0, the first cycle after reset enters RUN directly.
- CLEAR state:
  - Each cycle writes 0 to ram[counter] and increments the counter.
  - After word 2**ADDR_WIDTH-1 is written, the next state is RUN.
  - The sweep therefore takes exactly 2**ADDR_WIDTH cycles. req_ready = 0 throughout.
- RUN state: req_ready = 1 every cycle. A request is accepted on any edge where req_valid & req_ready.
- Error check, per request:
  - err = (2**req_size > LANES) or (byte offset not a multiple of 2**req_size).
  - On error, no RAM write occurs, resp_err = 1, and resp_data = 0.
- Store:
  - Byte-enable mask = (2**(2**req_size) - 1) << offset. Every combination of lanes is legal.
  - req_wdata is shifted left by 8*offset bits.
  - Only enabled bytes are written; the other bytes of the word are preserved.
- Load:
  - The whole word is read and shifted right by 8*offset bits.
  - The result is truncated to 2**req_size bytes, then extended to DATA_WIDTH: sign-extended from its top bit if req_signed, otherwise zero-extended.
  - A full-width load ignores req_signed.
- The RAM has a single port, and there is at most one access per cycle, so no read/write collision can occur.

## Timing
- Latency is one cycle. A request accepted at edge N produces resp_valid/resp_data/resp_err valid after edge N and until edge N+1.
- Throughput is one request per cycle; back-to-back requests are allowed.
- The store write takes effect at the accepting edge. A load accepted on the next edge returns the new data.
- resp_valid = 0 in every cycle that follows an edge with no accept. resp_data and resp_err are 0 whenever resp_valid = 0.
- Reset:
  - rst asserted mid-sweep restarts the sweep from word 0.
  - rst asserted in RUN drops any pending response: resp_valid = 0 after that edge.
- A request presented while req_ready = 0 is ignored. It is neither queued nor answered.
- Boundary:
  - The highest byte address (all ones) with req_size = 0 is legal and accesses the top word.
  - The clear counter does not wrap into RUN early. The transition to RUN is decided by the last index, not by overflow.

## Test plan
- Reset, CLEAR_ON_RESET = 1, ADDR_WIDTH = 4 → req_ready = 0 for exactly 16 cycles after rst falls, then 1; word loads at 0x00..0x3C all return 0 with resp_err = 0.
- Store word 0x11223344 @0x08, then store byte 0xAB @0x09 → word load @0x08 returns 0x1122AB44; unsigned byte load @0x09 returns 0x000000AB; signed byte load @0x09 returns 0xFFFFFFAB.
- Signed half load @0x0A of 0x8001 → 0xFFFF8001; unsigned half load → 0x00008001.
- Half store @0x03, word load @0x06, and req_size = 3 with DATA_WIDTH = 32 → each gives resp_err = 1, resp_data = 0, and memory unchanged (a word reread of that word matches its prior value).
- Back-to-back stream, req_valid held high: store 0xCAFEBABE @0x10, load @0x10, store byte 0x00 @0x13, load @0x10 → responses on four consecutive cycles with data 0, 0xCAFEBABE, 0, 0x00FEBABE.
- rst pulsed for 1 cycle during the sweep (at counter = 7) → a full 2**ADDR_WIDTH-cycle sweep restarts; a request held valid during the sweep gets no response until RUN, then exactly one response.
